// File: rtl/note_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : note_event_queue_pkg
//  Purpose  : Note event types shared by duration_detector, note_event_queue
//             and the score writer. Holds the duration code enum, the packed
//             event layout and the flag-to-code priority encoder.
//  Revision : 1.0  initial release
// ============================================================================
package note_event_queue_pkg;

    localparam int C_TONE_W = 6;

    typedef enum logic [1:0] {
        DUR_EIGHTH  = 2'd0,
        DUR_QUARTER = 2'd1,
        DUR_HALF    = 2'd2,
        DUR_WHOLE   = 2'd3
    } dur_e;

    typedef struct packed {
        logic                is_rest;
        dur_e                dur;
        logic [C_TONE_W-1:0] tone;
    } note_event_t;

    // Result of flag decoding; valid=0 means no flag was set.
    typedef struct packed {
        logic valid;
        logic is_rest;
        dur_e dur;
    } flag_code_t;

    // flags = {whole_note, half_note, quarter_note, eighth_note,
    //          whole_rest, half_rest, quarter_rest, eighth_rest}.
    // Notes outrank rests; longer durations outrank shorter ones.
    function automatic flag_code_t encode_flags(input logic [7:0] flags);
        flag_code_t c;
        c = '{valid: 1'b1, is_rest: 1'b0, dur: DUR_EIGHTH};
        if      (flags[7]) c.dur = DUR_WHOLE;
        else if (flags[6]) c.dur = DUR_HALF;
        else if (flags[5]) c.dur = DUR_QUARTER;
        else if (flags[4]) c.dur = DUR_EIGHTH;
        else if (flags[3]) c = '{valid: 1'b1, is_rest: 1'b1, dur: DUR_WHOLE};
        else if (flags[2]) c = '{valid: 1'b1, is_rest: 1'b1, dur: DUR_HALF};
        else if (flags[1]) c = '{valid: 1'b1, is_rest: 1'b1, dur: DUR_QUARTER};
        else if (flags[0]) c = '{valid: 1'b1, is_rest: 1'b1, dur: DUR_EIGHTH};
        else               c = '{valid: 1'b0, is_rest: 1'b0, dur: DUR_EIGHTH};
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : note_event_queue_if
//  Purpose  : Strobe/flag input bundle and event valid/ready stream of the
//             note event queue. master = detector + consumer side,
//             slave = the queue. NOTE_QUEUE_STATS_EN adds the stats outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface note_event_queue_if
    import note_event_queue_pkg::*;
#(
    parameter int TONE_W = C_TONE_W,
    parameter int DEPTH  = 16
);
    logic                     new_note_ready;
    logic [TONE_W-1:0]        new_note_tone;
    logic                     eighth_note;
    logic                     quarter_note;
    logic                     half_note;
    logic                     whole_note;
    logic                     eighth_rest;
    logic                     quarter_rest;
    logic                     half_rest;
    logic                     whole_rest;
    logic                     event_valid;
    logic [TONE_W+2:0]        event_data;
    logic                     event_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow_pulse;
    logic                     malformed_pulse;
`ifdef NOTE_QUEUE_STATS_EN
    logic [15:0]              drop_count;
    logic [$clog2(DEPTH):0]   high_water;
`endif

    modport master (
        output new_note_ready, new_note_tone,
        output eighth_note, quarter_note, half_note, whole_note,
        output eighth_rest, quarter_rest, half_rest, whole_rest,
        output event_ready,
        input  event_valid, event_data, count, overflow_pulse, malformed_pulse
`ifdef NOTE_QUEUE_STATS_EN
        , input drop_count, high_water
`endif
    );

    modport slave (
        input  new_note_ready, new_note_tone,
        input  eighth_note, quarter_note, half_note, whole_note,
        input  eighth_rest, quarter_rest, half_rest, whole_rest,
        input  event_ready,
        output event_valid, event_data, count, overflow_pulse, malformed_pulse
`ifdef NOTE_QUEUE_STATS_EN
        , output drop_count, high_water
`endif
    );
endinterface
`default_nettype wire

// File: rtl/note_event_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : note_fifo
//  Purpose  : Generic synchronous first-word-fall-through FIFO. o_rdata shows
//             the head whenever not empty and reads zero when empty.
//             Push on full is ignored unless a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module note_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int C_AW = $clog2(DEPTH);
    localparam logic [C_AW:0] C_FULL = C_AW'(0) + (C_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == C_FULL);
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write; contents need no reset since o_rdata is masked when empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count moves by +1/-1/0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/note_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : note_event_queue
//  Purpose  : Encodes each new_note_ready strobe into a {is_rest, dur, tone}
//             event and queues it for a slower valid/ready consumer. Drops
//             are flagged by overflow_pulse (full) and malformed_pulse
//             (no duration flag). Optional macro NOTE_QUEUE_STATS_EN adds
//             drop_count and high_water.
//  Revision : 1.0  initial release
// ============================================================================
module note_event_queue
    import note_event_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TONE_W = C_TONE_W
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    note_event_queue_if.slave  bus
);
    localparam int C_CW = $clog2(DEPTH) + 1;

    flag_code_t          w_code;
    logic [TONE_W+2:0]   w_event;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [C_CW-1:0]     w_count;
    logic                r_overflow_pulse;
    logic                r_malformed_pulse;

    // Flag decode and event packing; rests carry a zero tone.
    always_comb begin
        w_code  = encode_flags({bus.whole_note, bus.half_note, bus.quarter_note,
                                bus.eighth_note, bus.whole_rest, bus.half_rest,
                                bus.quarter_rest, bus.eighth_rest});
        w_event = {w_code.is_rest, w_code.dur,
                   w_code.is_rest ? {TONE_W{1'b0}} : bus.new_note_tone};
    end

    // A pop only exists when the head is valid, so empty+push+ready is push-only.
    assign w_push_req = bus.new_note_ready && w_code.valid;
    assign w_pop      = !w_empty && bus.event_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);

    note_fifo #(
        .WIDTH (TONE_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_event),
        .o_rdata (bus.event_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.event_valid     = !w_empty;
    assign bus.count           = w_count;
    assign bus.overflow_pulse  = r_overflow_pulse;
    assign bus.malformed_pulse = r_malformed_pulse;

    // Drop indications, one cycle after the offending strobe.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_overflow_pulse  <= 1'b0;
            r_malformed_pulse <= 1'b0;
        end else begin
            r_overflow_pulse  <= w_push_req && w_full && !w_pop;
            r_malformed_pulse <= bus.new_note_ready && !w_code.valid;
        end
    end

`ifdef NOTE_QUEUE_STATS_EN
    logic [15:0]     r_drop_count;
    logic [C_CW-1:0] r_high_water;
    logic            w_drop;

    assign w_drop         = (w_push_req && w_full && !w_pop)
                          || (bus.new_note_ready && !w_code.valid);
    assign bus.drop_count = r_drop_count;
    assign bus.high_water = r_high_water;

    // Saturating drop counter and peak occupancy tracker.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_drop_count <= '0;
            r_high_water <= '0;
        end else begin
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
            if (w_count > r_high_water)               r_high_water <= w_count;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_note_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_event_queue
//  Purpose  : Self-checking bench for note_event_queue: directed vector table
//             plus hand-written fill/overflow/drain and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_event_queue;
    localparam int DEPTH  = 16;
    localparam int TONE_W = 6;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    note_event_queue_if #(.TONE_W(TONE_W), .DEPTH(DEPTH)) bus_if ();

    note_event_queue #(.DEPTH(DEPTH), .TONE_W(TONE_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    always #5 clk_in = ~clk_in;

    // flags = {wn, hn, qn, en, wr, hr, qr, er}
    typedef struct {
        logic       strobe;
        logic [5:0] tone;
        logic [7:0] flags;
        logic       rdy;
        logic       exp_valid;
        logic [8:0] exp_data;
        logic [4:0] exp_count;
        logic       exp_ovf;
        logic       exp_mal;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic strobe, input logic [5:0] tone,
                         input logic [7:0] flags, input logic rdy);
        bus_if.new_note_ready = strobe;
        bus_if.new_note_tone  = tone;
        {bus_if.whole_note, bus_if.half_note, bus_if.quarter_note, bus_if.eighth_note,
         bus_if.whole_rest, bus_if.half_rest, bus_if.quarter_rest, bus_if.eighth_rest} = flags;
        bus_if.event_ready    = rdy;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 6'd10, 8'b0010_0000, 1'b0, 1'b1, 9'h04A, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 6'd20, 8'b0000_0100, 1'b0, 1'b1, 9'h04A, 5'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b1, 9'h180, 5'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 6'd5,  8'b0000_0000, 1'b0, 1'b0, 9'h000, 5'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 6'd7,  8'b0001_1000, 1'b0, 1'b1, 9'h007, 5'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 6'd3,  8'b1000_0000, 1'b1, 1'b1, 9'h0C3, 5'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 6'd63, 8'b0000_1000, 1'b1, 1'b1, 9'h1C0, 5'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 6'd1,  8'b0000_0011, 1'b0, 1'b1, 9'h140, 5'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 6'd2,  8'b0000_0001, 1'b0, 1'b1, 9'h140, 5'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b1, 9'h100, 5'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 6'd0,  8'b0000_0000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0, 1'b0};

        // Reset state
        drive(1'b0, '0, '0, 1'b0);
        rst_in = 1'b1;
        step(); step();
        rst_in = 1'b0;
        check("reset_valid", 32'(bus_if.event_valid), 32'd0);
        check("reset_data",  32'(bus_if.event_data), 32'd0);
        check("reset_count", 32'(bus_if.count), 32'd0);
        check("reset_ovf",   32'(bus_if.overflow_pulse), 32'd0);
        check("reset_mal",   32'(bus_if.malformed_pulse), 32'd0);

        // Directed vector table, one cycle per record
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].strobe, vecs[i].tone, vecs[i].flags, vecs[i].rdy);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus_if.event_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  32'(bus_if.event_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_count", i), 32'(bus_if.count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovf", i),   32'(bus_if.overflow_pulse), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_mal", i),   32'(bus_if.malformed_pulse), 32'(vecs[i].exp_mal));
        end
        drive(1'b0, '0, '0, 1'b0);
        step();

        // Fill with 16 quarter notes (tone = index), then one more is dropped
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 6'(i), 8'b0010_0000, 1'b0);
            step();
        end
        check("fill_count", 32'(bus_if.count), 32'd16);
        check("fill_ovf_quiet", 32'(bus_if.overflow_pulse), 32'd0);
        drive(1'b1, 6'd50, 8'b0010_0000, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("ovf_pulse", 32'(bus_if.overflow_pulse), 32'd1);
        check("ovf_count", 32'(bus_if.count), 32'd16);
        check("ovf_head",  32'(bus_if.event_data), 32'h040);
        step();
        check("ovf_pulse_once", 32'(bus_if.overflow_pulse), 32'd0);
        check("hold_head", 32'(bus_if.event_data), 32'h040);

        // Full + push + pop: tone 0 leaves, tone 40 joins at the tail
        drive(1'b1, 6'd40, 8'b0010_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("fullpp_count", 32'(bus_if.count), 32'd16);
        check("fullpp_ovf",   32'(bus_if.overflow_pulse), 32'd0);

`ifdef NOTE_QUEUE_STATS_EN
        check("stats_drop", 32'(bus_if.drop_count), 32'd2);
        check("stats_hw",   32'(bus_if.high_water), 32'd16);
`endif

        // Drain: tones 1..15 then 40
        for (int i = 0; i < 16; i++) begin
            logic [8:0] exp_d;
            exp_d = {1'b0, 2'd1, (i < 15) ? 6'(i + 1) : 6'd40};
            check($sformatf("drain%0d_valid", i), 32'(bus_if.event_valid), 32'd1);
            check($sformatf("drain%0d_data", i),  32'(bus_if.event_data), 32'(exp_d));
            drive(1'b0, '0, '0, 1'b1);
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        check("drain_empty", 32'(bus_if.event_valid), 32'd0);
        check("drain_count", 32'(bus_if.count), 32'd0);

        // Mid-stream reset overrides a concurrent push and pop
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6'(i + 30), 8'b0100_0000, 1'b0);
            step();
        end
        check("pre_rst_count", 32'(bus_if.count), 32'd5);
        drive(1'b1, 6'd9, 8'b1000_0000, 1'b1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("rst_valid", 32'(bus_if.event_valid), 32'd0);
        check("rst_count", 32'(bus_if.count), 32'd0);
        check("rst_data",  32'(bus_if.event_data), 32'd0);
`ifdef NOTE_QUEUE_STATS_EN
        check("rst_drop", 32'(bus_if.drop_count), 32'd0);
        check("rst_hw",   32'(bus_if.high_water), 32'd0);
`endif
        step();
        check("post_rst_count", 32'(bus_if.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
